// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the 8-way round-robin arbiter
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick: first set request at or after ptr, mod 8
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   k;

    // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate the index back.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        k   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = SEL_W'(i);
            end
        end
        any = |req;
        idx = ptr + k;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin owner selection and beat pacing for the shared 8:1 mux
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int BEAT_W    = $clog2(MAX_BEATS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             out_valid,
    output logic [N_REQ-1:0] beat_ack
);

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [SEL_W-1:0] owner, owner_n;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             accept;
    logic             last_beat;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign out_valid = (state == GRANT) & req[owner];
    assign accept    = out_valid & out_ready;
    assign last_beat = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign beat_ack  = accept ? gnt : '0;
    // owner is only updated on a new grant, so sel holds its value through IDLE.
    assign sel       = owner;

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        beat_cnt_n = beat_cnt;
        gnt_n      = gnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n    = GRANT;
                    owner_n    = pick_idx;
                    gnt_n      = N_REQ'(1) << pick_idx;
                    beat_cnt_n = '0;
                end
            end
            GRANT: begin
                if (!req[owner] || (accept && last_beat)) begin
                    state_n    = IDLE;
                    gnt_n      = '0;
                    ptr_n      = owner + SEL_W'(1);
                    beat_cnt_n = '0;
                end else if (accept) begin
                    beat_cnt_n = beat_cnt + BEAT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            beat_cnt <= beat_cnt_n;
            gnt      <= gnt_n;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - scoreboard bench for the 8-way round-robin arbiter
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    bit         clk_en = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out_valid;
    logic [7:0] beat_ack;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    mux8_rr_arbiter #(.MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .beat_ack  (beat_ack)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [7:0] oh, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(oh);
    endtask

    // Monitor: every accepted beat must match the next expected owner.
    always @(negedge clk) begin
        logic [7:0] e;
        if (beat_ack != 8'h00) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got %h expected none at %0t", beat_ack, $time);
            end else begin
                e = exp_q.pop_front();
                chk("beat_ack", beat_ack, e);
                chk("beat_gnt", gnt, e);
            end
        end
    end

    initial begin
        // 1: reset with no clock running
        #1 rst = 1'b1;
        #2;
        chk("rst_sel", {5'd0, sel}, 8'h00);
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_ack", beat_ack, 8'h00);
        clk_en = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_gnt", gnt, 8'h00);

        // 2: single requester 3, full burst then regrant after one bubble
        req = 8'h08; out_ready = 1'b1;
        push_beats(8'h08, 4);
        tick();
        chk("t2_gnt", gnt, 8'h08);
        chk("t2_sel", {5'd0, sel}, 8'h03);
        chk("t2_valid", {7'd0, out_valid}, 8'h01);
        repeat (4) tick();
        chk("t2_bubble_gnt", gnt, 8'h00);
        chk("t2_bubble_valid", {7'd0, out_valid}, 8'h00);
        tick();
        chk("t2_regnt", gnt, 8'h08);
        out_ready = 1'b0; req = 8'h00;
        tick();
        chk("t2_rel_gnt", gnt, 8'h00);
        chk("t2_sel_kept", {5'd0, sel}, 8'h03);

        // 3: all requesting, fresh pointer -> 0..7,0
        rst = 1'b1; #1; rst = 1'b0;
        req = 8'hFF; out_ready = 1'b1;
        for (int g = 0; g < 9; g++) push_beats(8'h01 << (g % 8), 4);
        for (int g = 0; g < 9; g++) begin
            tick();
            chk("t3_gnt", gnt, 8'h01 << (g % 8));
            chk("t3_sel", {5'd0, sel}, 8'(g % 8));
            repeat (4) tick();
        end
        chk("t3_end_gnt", gnt, 8'h00);
        req = 8'h00;
        tick();

        // 4: owner 5 drops after 2 beats, next grant goes to 6
        req = 8'h20; out_ready = 1'b1;
        push_beats(8'h20, 2);
        tick();
        chk("t4_gnt5", gnt, 8'h20);
        repeat (2) tick();
        req = 8'h41;
        tick();
        chk("t4_drop_gnt", gnt, 8'h00);
        tick();
        chk("t4_gnt6", gnt, 8'h40);
        chk("t4_sel6", {5'd0, sel}, 8'h06);
        out_ready = 1'b0; req = 8'h00;
        tick();
        chk("t4_rel", gnt, 8'h00);

        // 5: backpressure on owner 2 holds the grant without consuming beats
        req = 8'h04; out_ready = 1'b0;
        tick();
        chk("t5_gnt", gnt, 8'h04);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_gnt", gnt, 8'h04);
            chk("t5_hold_valid", {7'd0, out_valid}, 8'h01);
            chk("t5_hold_ack", beat_ack, 8'h00);
        end
        out_ready = 1'b1;
        push_beats(8'h04, 4);
        repeat (3) tick();
        chk("t5_mid_gnt", gnt, 8'h04);
        tick();
        chk("t5_rel", gnt, 8'h00);
        req = 8'h00;
        tick();

        // 6: async reset mid-burst, pointer returns to 0
        req = 8'h10; out_ready = 1'b1;
        push_beats(8'h10, 2);
        tick();
        chk("t6_gnt4", gnt, 8'h10);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 8'h00);
        chk("t6_rst_sel", {5'd0, sel}, 8'h00);
        chk("t6_rst_valid", {7'd0, out_valid}, 8'h00);
        chk("t6_rst_ack", beat_ack, 8'h00);
        tick();
        rst = 1'b0; req = 8'h11;
        tick();
        chk("t6_gnt0", gnt, 8'h01);
        chk("t6_sel0", {5'd0, sel}, 8'h00);
        out_ready = 1'b0; req = 8'h00;
        tick();
        chk("t6_rel", gnt, 8'h00);

        repeat (2) tick();
        chk("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
